// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory/MMIO port between two masters, one transaction in flight.
// Latency: grant in IDLE, mem_en next cycle, rvalid RD_LAT+1 cycles after mem_en; the loser sees gnt=0 and holds req.
module dmem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                m0_req,
   input  logic                m0_we,
   input  logic [ADDR_W-1:0]   m0_addr,
   input  logic [DATA_W-1:0]   m0_wdata,
   input  logic [DATA_W/8-1:0] m0_be,
   output logic                m0_gnt,
   output logic                m0_rvalid,
   output logic [DATA_W-1:0]   m0_rdata,
   input  logic                m1_req,
   input  logic                m1_we,
   input  logic [ADDR_W-1:0]   m1_addr,
   input  logic [DATA_W-1:0]   m1_wdata,
   input  logic [DATA_W/8-1:0] m1_be,
   output logic                m1_gnt,
   output logic                m1_rvalid,
   output logic [DATA_W-1:0]   m1_rdata,
   output logic                mem_en,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_be,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                busy
);

   localparam int BE_W = DATA_W/8;
   localparam logic [1:0] CNT_INIT = 2'(RD_LAT-1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_last;
   logic                r_cmd_id;
   logic                r_cmd_we;
   logic [ADDR_W-1:0]   r_cmd_addr;
   logic [DATA_W-1:0]   r_cmd_wdata;
   logic [BE_W-1:0]     r_cmd_be;
   logic [1:0]          r_cnt;
   logic                r_rvalid0;
   logic                r_rvalid1;
   logic [DATA_W-1:0]   r_rdata0;
   logic [DATA_W-1:0]   r_rdata1;
   logic                w_gnt0;
   logic                w_gnt1;
   logic                w_cap;
   logic                w_issue;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Grants are gated by rst so nothing is accepted while reset is held.
   always_comb begin
      w_state_nxt = r_state;
      w_gnt0      = 1'b0;
      w_gnt1      = 1'b0;
      w_cap       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (rst) begin
               w_gnt0 = m0_req & (~m1_req | r_last);
               w_gnt1 = m1_req & (~m0_req | ~r_last);
            end
            if (w_gnt0 | w_gnt1) w_state_nxt = S_ISSUE;
         end
         S_ISSUE: w_state_nxt = r_cmd_we ? S_IDLE : S_WAIT;
         S_WAIT: begin
            if (r_cnt == 2'd0) begin
               w_cap       = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_last      <= 1'b1;
         r_cmd_id    <= 1'b0;
         r_cmd_we    <= 1'b0;
         r_cmd_addr  <= '0;
         r_cmd_wdata <= '0;
         r_cmd_be    <= '0;
         r_cnt       <= 2'd0;
         r_rvalid0   <= 1'b0;
         r_rvalid1   <= 1'b0;
         r_rdata0    <= '0;
         r_rdata1    <= '0;
      end else begin
         r_rvalid0 <= w_cap & ~r_cmd_id;
         r_rvalid1 <= w_cap & r_cmd_id;
         if (w_gnt0 | w_gnt1) begin
            r_cmd_id    <= w_gnt1;
            r_last      <= w_gnt1;
            r_cmd_we    <= w_gnt1 ? m1_we    : m0_we;
            r_cmd_addr  <= w_gnt1 ? m1_addr  : m0_addr;
            r_cmd_wdata <= w_gnt1 ? m1_wdata : m0_wdata;
            r_cmd_be    <= w_gnt1 ? m1_be    : m0_be;
         end
         if (r_state == S_ISSUE) begin
            r_cnt <= CNT_INIT;
         end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt - 2'd1;
         end
         if (w_cap & ~r_cmd_id) r_rdata0 <= mem_rdata;
         if (w_cap &  r_cmd_id) r_rdata1 <= mem_rdata;
      end
   end

   // Address/data are forced to zero outside ISSUE so MMIO decode never sees a stale access.
   assign w_issue   = (r_state == S_ISSUE);
   assign mem_en    = w_issue;
   assign mem_we    = w_issue & r_cmd_we;
   assign mem_addr  = w_issue ? r_cmd_addr  : '0;
   assign mem_wdata = w_issue ? r_cmd_wdata : '0;
   assign mem_be    = w_issue ? r_cmd_be    : '0;
   assign busy      = (r_state != S_IDLE);
   assign m0_gnt    = w_gnt0;
   assign m1_gnt    = w_gnt1;
   assign m0_rvalid = r_rvalid0;
   assign m1_rvalid = r_rvalid1;
   assign m0_rdata  = r_rdata0;
   assign m1_rdata  = r_rdata1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: timeline model of grants/issue/rvalid plus a byte-enabled memory behind the port.
module tb_dmem_arbiter;
   localparam int RD_LAT = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic [3:0]  m0_be, m1_be;
   logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
   logic [31:0] m0_rdata, m1_rdata;
   logic        mem_en, mem_we, busy;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   int          n_pass = 0, n_total = 0;
   int          k = 0;
   logic [31:0] mem_arr [16];
   logic [31:0] pend_d  [8];
   bit          pend_v  [8];

   // Model state: cycle numbers at which things must happen.
   int          free_c = 0, iss_c = -1, rv_c = -1;
   bit          last = 1'b1, rv_m;
   bit          c_we;
   logic [31:0] c_addr, c_wdata, rv_dat, e_rd0 = '0, e_rd1 = '0;
   logic [3:0]  c_be;
   bit          g0, g1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s cycle %0d: got %0h expected %0h", nm, k, act, exp);
   endtask

   task automatic chk_cyc();
      bit idle, eg0, eg1, eiss, erv0, erv1;
      @(negedge clk);
      if (!rst) begin
         last = 1'b1; free_c = 0; iss_c = -1; rv_c = -1; e_rd0 = '0; e_rd1 = '0;
      end
      idle = rst && (k >= free_c);
      eg0  = idle && m0_req && (!m1_req || last);
      eg1  = idle && m1_req && (!m0_req || !last);
      eiss = rst && (k == iss_c);
      if (eiss && !c_we) rv_dat = mem_arr[c_addr[5:2]];
      erv0 = rst && (k == rv_c) && !rv_m;
      erv1 = rst && (k == rv_c) && rv_m;
      if (erv0) e_rd0 = rv_dat;
      if (erv1) e_rd1 = rv_dat;
      chk("m0_gnt", m0_gnt, eg0);
      chk("m1_gnt", m1_gnt, eg1);
      chk("busy", busy, rst && (k < free_c));
      chk("mem_en", mem_en, eiss);
      chk("mem_we", mem_we, eiss && c_we);
      chk("mem_addr", mem_addr, eiss ? c_addr : 32'h0);
      chk("mem_wdata", mem_wdata, eiss ? c_wdata : 32'h0);
      chk("mem_be", mem_be, eiss ? c_be : 4'h0);
      chk("m0_rvalid", m0_rvalid, erv0);
      chk("m1_rvalid", m1_rvalid, erv1);
      chk("m0_rdata", m0_rdata, e_rd0);
      chk("m1_rdata", m1_rdata, e_rd1);
      g0 = m0_gnt; g1 = m1_gnt;
      if (eg0 || eg1) begin
         rv_m    = eg1;
         last    = eg1;
         c_we    = eg1 ? m1_we    : m0_we;
         c_addr  = eg1 ? m1_addr  : m0_addr;
         c_wdata = eg1 ? m1_wdata : m0_wdata;
         c_be    = eg1 ? m1_be    : m0_be;
         iss_c   = k + 1;
         free_c  = c_we ? k + 2 : k + 2 + RD_LAT;
         if (!c_we) rv_c = k + 2 + RD_LAT;
      end
      // Memory behind the port reacts to what the DUT actually drives.
      if (mem_en && mem_we) begin
         for (int b = 0; b < 4; b++)
            if (mem_be[b]) mem_arr[mem_addr[5:2]][8*b +: 8] = mem_wdata[8*b +: 8];
      end else if (mem_en) begin
         pend_d[(k + RD_LAT) % 8] = mem_arr[mem_addr[5:2]];
         pend_v[(k + RD_LAT) % 8] = 1'b1;
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
      k++;
      if (pend_v[k % 8]) begin
         mem_rdata = pend_d[k % 8];
         pend_v[k % 8] = 1'b0;
      end else begin
         mem_rdata = $urandom;
      end
   endtask

   task automatic step();
      chk_cyc();
      adv();
   endtask

   task automatic drain();
      for (int i = 0; i < 12; i++) step();
   endtask

   initial begin
      int ng, nen, c0;
      bit prev_en, done;
      for (int i = 0; i < 16; i++) mem_arr[i] = $urandom;
      for (int i = 0; i < 8; i++) pend_v[i] = 1'b0;
      mem_arr[8] = 32'h1234_5678;
      rst = 1'b0; mem_rdata = '0;
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h10; m0_wdata = 32'hDEAD_BEEF; m0_be = 4'hF;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h20; m1_wdata = 32'h0;         m1_be = 4'hF;
      @(posedge clk); #1;

      // Reset held with both requests pending.
      for (int i = 0; i < 3; i++) begin
         chk_cyc();
         chk("rst_outs", {m0_gnt, m1_gnt, mem_en, mem_we, busy, m0_rvalid, m1_rvalid}, 0);
         chk("rst_bus", {mem_addr, mem_wdata}, 0);
         adv();
      end
      rst = 1'b1;
      chk_cyc();
      chk("rel_m0_gnt", {m0_gnt, m1_gnt}, 2'b10);
      adv();
      m0_req = 1'b0;
      chk_cyc();
      chk("wr_mem_en_we", {mem_en, mem_we}, 2'b11);
      chk("wr_addr", mem_addr, 32'h10);
      chk("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("wr_be", mem_be, 4'hF);
      adv();
      chk_cyc();
      chk("wr_busy_low", busy, 0);
      chk("rd_m1_gnt", m1_gnt, 1);
      adv();
      m1_req = 1'b0;
      chk_cyc();
      chk("rd_mem_en", {mem_en, mem_we}, 2'b10);
      chk("rd_addr", mem_addr, 32'h20);
      adv();
      step(); step();
      chk_cyc();
      chk("rd_m1_rvalid", m1_rvalid, 1);
      chk("rd_m1_rdata", m1_rdata, 32'h1234_5678);
      chk("rd_m0_rvalid", m0_rvalid, 0);
      adv();
      drain();

      // Fairness: both held, each master toggles read/write after its grants.
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = $urandom; m0_wdata = $urandom; m0_be = 4'hF;
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = $urandom; m1_wdata = $urandom; m1_be = 4'h3;
      ng = 0; nen = 0; prev_en = 1'b0;
      for (int c = 0; c < 80; c++) begin
         chk_cyc();
         if (g0 || g1) begin
            chk("fair_order", g1, ng % 2);
            ng++;
         end
         if (mem_en) nen++;
         chk("no_b2b_en", prev_en && mem_en, 0);
         prev_en = mem_en;
         adv();
         if (g0) begin m0_we = ~m0_we; m0_addr = $urandom; m0_wdata = $urandom; end
         if (g1) begin m1_we = ~m1_we; m1_addr = $urandom; m1_wdata = $urandom; end
         if (ng >= 6) begin m0_req = 1'b0; m1_req = 1'b0; end
         if (ng >= 6 && !busy && !mem_en) break;
      end
      drain();
      chk("fair_grants", ng, 6);
      chk("fair_mem_en", nen, 6);

      // Back-to-back: M0 read then M0 write granted in the rvalid cycle.
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = $urandom; m0_be = 4'hF;
      done = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
         chk_cyc();
         done = g0;
         adv();
      end
      chk("b2b_rd_gnt", done, 1);
      m0_we = 1'b1; m0_addr = $urandom; m0_wdata = $urandom;
      step(); step(); step();
      chk_cyc();
      chk("b2b_rvalid_gnt", {m0_rvalid, m0_gnt}, 2'b11);
      adv();
      m0_req = 1'b0;
      drain();

      // Reset during WAIT aborts the read and restores M0 tie priority.
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = $urandom;
      chk_cyc();
      chk("abort_gnt", m0_gnt, 1);
      adv();
      m0_req = 1'b0;
      step();
      chk_cyc();
      chk("abort_in_wait", busy, 1);
      adv();
      rst = 1'b0;
      m0_req = 1'b1; m0_we = 1'b1; m1_req = 1'b1; m1_we = 1'b1;
      c0 = k;
      for (int c = 0; c < 2; c++) begin
         chk_cyc();
         chk("abort_idle", {busy, m0_rvalid}, 0);
         adv();
      end
      rst = 1'b1;
      chk_cyc();
      chk("abort_tie_m0", {m0_gnt, m1_gnt}, 2'b10);
      adv();
      m0_req = 1'b0;
      for (int c = 0; c < 6; c++) begin
         chk_cyc();
         chk("abort_no_rv", m0_rvalid, 0);
         adv();
         if (g1) m1_req = 1'b0;
      end
      if (k - c0 > 20) chk("abort_budget", k - c0, 0);
      drain();

      // Randomised traffic with occasional withdrawals and resets.
      for (int c = 0; c < 3000; c++) begin
         chk_cyc();
         adv();
         rst = ($urandom % 400) != 0;
         if (!m0_req || g0) begin
            m0_req = ($urandom % 3) != 0; m0_we = $urandom; m0_addr = $urandom;
            m0_wdata = $urandom; m0_be = $urandom;
         end else if ($urandom % 10 == 0) m0_req = 1'b0;
         if (!m1_req || g1) begin
            m1_req = ($urandom % 3) != 0; m1_we = $urandom; m1_addr = $urandom;
            m1_wdata = $urandom; m1_be = $urandom;
         end else if ($urandom % 10 == 0) m1_req = 1'b0;
      end
      rst = 1'b1; m0_req = 1'b0; m1_req = 1'b0;
      drain();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Round-robin arbiter sharing the single data-memory/MMIO port (data_src + mmio) between two requesters.
- M0 is the pipeline_unit data port; M1 is a second master (UART boot loader / debug loader).
- Exactly one transaction is outstanding at a time. Grants are registered into an internal command register before being issued, so the memory path never sees a combinational mux from requester inputs.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width. BE width = DATA_W/8.
- RD_LAT, 1, memory read latency in cycles from the mem_en cycle to mem_rdata valid. Legal range 1..4.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- m0_req  in  1  M0 request; held with fields stable until m0_gnt.
- m0_we  in  1  1 = write, 0 = read.
- m0_addr  in  ADDR_W  byte address.
- m0_wdata  in  DATA_W  write data.
- m0_be  in  DATA_W/8  byte enables.
- m0_gnt  out  1  one-cycle accept pulse (combinational in IDLE).
- m0_rvalid  out  1  one-cycle read-data-valid pulse.
- m0_rdata  out  DATA_W  read data; valid only with m0_rvalid.
- m1_req, m1_we, m1_addr, m1_wdata, m1_be, m1_gnt, m1_rvalid, m1_rdata: same as M0.
- mem_en  out  1  memory access strobe, one cycle per transaction.
- mem_we  out  1  write strobe, qualified by mem_en.
- mem_addr  out  ADDR_W  address to data_src/mmio.
- mem_wdata  out  DATA_W  write data.
- mem_be  out  DATA_W/8  byte enables.
- mem_rdata  in  DATA_W  read data, valid RD_LAT cycles after mem_en.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- States: IDLE, ISSUE, WAIT.
- Reset (rst=0, async): state=IDLE; last=1 (M0 wins the first tie). All outputs 0: gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata, mem_be, busy.
- IDLE, arbitration (combinational):
  - Only one req high: that master wins.
  - Both high: the master != last wins.
  - gnt pulses for the winner in this cycle.
  - At the clock edge: winner id, we, addr, wdata and be are latched into the command register; last <= winner; state -> ISSUE.
  - No req: stay in IDLE; all gnt = 0.
- ISSUE (exactly 1 cycle):
  - mem_en=1; mem_we/addr/wdata/be driven from the command register.
  - If write: state -> IDLE.
  - If read: load counter = RD_LAT-1; state -> WAIT.
- WAIT:
  - mem_en=0. Counter decrements each cycle.
  - In the cycle where counter == 0, mem_rdata is valid. It is captured into the winner's rdata register, rvalid is set for the next cycle, and state -> IDLE.
- rvalid/rdata timing:
  - rvalid is a registered one-cycle pulse, coincident with the first IDLE cycle after WAIT.
  - A new grant may occur in that same cycle.
  - rdata holds its last value until the next read for that master.
- Latency (req seen in IDLE at cycle 0):
  - Write: mem_en at cycle 1; next grant possible at cycle 2.
  - Read: mem_en at cycle 1; data captured at end of cycle 1+RD_LAT; rvalid at cycle 2+RD_LAT.
- Requester rules:
  - Dropping req before gnt is legal (request withdrawn); no transaction is issued.
  - req held after gnt is treated as a new request in the next IDLE cycle.
- Fairness: with both reqs held continuously, grants alternate M0, M1, M0, ... No master waits more than one foreign transaction.
- mem_* outputs return to 0 outside ISSUE (mem_addr, mem_wdata and mem_be are zeroed so the mmio decode sees no stale access).
- Reset mid-transaction: aborts immediately. No rvalid is produced for the aborted read, and last returns to 1.

Test Plan:
- Reset: hold rst=0 for 3 cycles with both reqs high -> every output 0, busy=0; on release, m0_gnt=1 in the first cycle.
- M0 write: addr=0x0000_0010, wdata=0xDEADBEEF, be=4'hF -> m0_gnt at cycle 0; cycle 1 shows mem_en=1, mem_we=1 with those exact values; busy low again at cycle 2.
- M1 read with RD_LAT=2, addr=0x0000_0020, memory returns 0x1234_5678 -> mem_en at cycle 1; m1_rvalid=1 and m1_rdata=0x12345678 at cycle 4; m0_rvalid stays 0.
- Both reqs held for 6 grants (alternating reads and writes) -> grant order M0, M1, M0, M1, M0, M1; exactly one mem_en per grant; no mem_en in consecutive cycles.
- Back-to-back: M0 read immediately followed by M0 write -> write granted in the same cycle as the read's rvalid pulse; ordering is preserved.
- Reset mid-read: assert rst=0 during WAIT -> state IDLE, no rvalid ever produced for that read; the next tie is granted to M0.
